// File: rtl/mag_ram_wr_ctrl.sv
`default_nettype none
// ============================================================================
// mag_ram_wr_ctrl : writes framed FFT magnitude bins into a two-bank RAM,
//                   single-shot or continuous ping-pong. Optional peak search
//                   is enabled by defining MAG_PEAK_TRACK_EN.
// Revision        : 1.0  initial release
// ============================================================================
module mag_ram_wr_ctrl #(
  parameter int DW        = 16,
  parameter int AW        = 12,
  parameter int DEPTH     = 4096,
  parameter int PEAK_SKIP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          cont_i,
  input  logic [DW-1:0] din_i,
  input  logic          din_valid_i,
  input  logic          din_last_i,
  output logic [DW-1:0] wr_data_o,
  output logic [AW:0]   wr_addr_o,
  output logic          wr_en_o,
  output logic          wr_done_o,
  output logic          frame_done_o,
  output logic          rd_bank_o,
  output logic          busy_o,
  output logic          err_sync_o,
  output logic [DW-1:0] peak_val_o,
  output logic [AW-1:0] peak_addr_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_BIN = AW'(DEPTH - 1);

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic [AW-1:0]   cnt_d;
  logic            bank_q;
  logic            cont_q;
  logic [DW-1:0]   wr_data_q;
  logic [AW:0]     wr_addr_q;
  logic            wr_en_q;
  logic            wr_done_q;
  logic            frame_done_q;
  logic            rd_bank_q;
  logic            err_sync_q;

  logic            w_beat;
  logic            w_frame_end;

  // A beat is a sample accepted for writing; abort suppresses it.
  assign w_beat      = (state_q == ST_CAPT) && din_valid_i && !abort_i;
  assign w_frame_end = w_beat && (cnt_q == LAST_BIN);
  assign cnt_d       = cnt_q + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bank_q       <= 1'b0;
      cont_q       <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_done_q    <= 1'b0;
      frame_done_q <= 1'b0;
      rd_bank_q    <= 1'b0;
      err_sync_q   <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (abort_i) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        wr_done_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start_i) begin
              state_q    <= ST_SYNC;
              wr_done_q  <= 1'b0;
              err_sync_q <= 1'b0;
              cont_q     <= cont_i;
            end
          end
          ST_SYNC: begin
            if (din_valid_i && din_last_i) begin
              state_q <= ST_CAPT;
              cnt_q   <= '0;
            end
          end
          ST_CAPT: begin
            if (w_beat) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= din_i;
              wr_addr_q <= {bank_q, cnt_q};
              if (w_frame_end) begin
                cnt_q        <= '0;
                frame_done_q <= 1'b1;
                rd_bank_q    <= bank_q;
                if (!din_last_i) err_sync_q <= 1'b1;
                if (cont_q) begin
                  bank_q <= ~bank_q;
                end else begin
                  state_q   <= ST_DONE;
                  wr_done_q <= 1'b1;
                end
              end else if (din_last_i) begin
                // Early last: drop this frame and realign on the next sample.
                err_sync_q <= 1'b1;
                cnt_q      <= '0;
              end else begin
                cnt_q <= cnt_d;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr_data_o    = wr_data_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_en_o      = wr_en_q;
  assign wr_done_o    = wr_done_q;
  assign frame_done_o = frame_done_q;
  assign rd_bank_o    = rd_bank_q;
  assign err_sync_o   = err_sync_q;
  assign busy_o       = (state_q == ST_SYNC) || (state_q == ST_CAPT);

`ifdef MAG_PEAK_TRACK_EN
  localparam logic [AW-1:0] SKIP_BIN = AW'(PEAK_SKIP);

  logic [DW-1:0] run_val_q;
  logic [AW-1:0] run_addr_q;
  logic [DW-1:0] peak_val_q;
  logic [AW-1:0] peak_addr_q;
  logic          w_take;
  logic [DW-1:0] w_best_val;
  logic [AW-1:0] w_best_addr;

  // The first eligible bin seeds the running max, so stale values from a
  // discarded frame never survive into the next one.
  always_comb begin
    w_take      = (cnt_q == SKIP_BIN) || ((cnt_q > SKIP_BIN) && (din_i > run_val_q));
    w_best_val  = w_take ? din_i : run_val_q;
    w_best_addr = w_take ? cnt_q : run_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_val_q   <= '0;
      run_addr_q  <= '0;
      peak_val_q  <= '0;
      peak_addr_q <= '0;
    end else if (w_beat) begin
      run_val_q  <= w_best_val;
      run_addr_q <= w_best_addr;
      if (w_frame_end) begin
        peak_val_q  <= w_best_val;
        peak_addr_q <= w_best_addr;
      end
    end
  end

  assign peak_val_o  = peak_val_q;
  assign peak_addr_o = peak_addr_q;
`else
  assign peak_val_o  = '0;
  assign peak_addr_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mag_ram_wr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mag_ram_wr_ctrl : directed/randomized bench for mag_ram_wr_ctrl.
// Revision           : 1.0  initial release
// ============================================================================
module tb_mag_ram_wr_ctrl;

  localparam int DW        = 16;
  localparam int AW        = 3;
  localparam int DEPTH     = 8;
  localparam int PEAK_SKIP = 1;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic          abort_i;
  logic          cont_i;
  logic [DW-1:0] din_i;
  logic          din_valid_i;
  logic          din_last_i;
  logic [DW-1:0] wr_data_o;
  logic [AW:0]   wr_addr_o;
  logic          wr_en_o;
  logic          wr_done_o;
  logic          frame_done_o;
  logic          rd_bank_o;
  logic          busy_o;
  logic          err_sync_o;
  logic [DW-1:0] peak_val_o;
  logic [AW-1:0] peak_addr_o;

  mag_ram_wr_ctrl #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .PEAK_SKIP(PEAK_SKIP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .cont_i(cont_i), .din_i(din_i), .din_valid_i(din_valid_i),
    .din_last_i(din_last_i), .wr_data_o(wr_data_o), .wr_addr_o(wr_addr_o),
    .wr_en_o(wr_en_o), .wr_done_o(wr_done_o), .frame_done_o(frame_done_o),
    .rd_bank_o(rd_bank_o), .busy_o(busy_o), .err_sync_o(err_sync_o),
    .peak_val_o(peak_val_o), .peak_addr_o(peak_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_chk;
  int            n_pass;
  logic          exp_err;
  logic          exp_rd;
  logic [DW-1:0] exp_pv;
  logic [AW-1:0] exp_pa;
  logic [DW-1:0] fr [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i     = 1'b0;
    abort_i     = 1'b0;
    din_valid_i = 1'b0;
    din_last_i  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_data"}, wr_data_o, 0);
    chk({tag, "_wr_addr"}, wr_addr_o, 0);
    chk({tag, "_wr_en"}, wr_en_o, 0);
    chk({tag, "_wr_done"}, wr_done_o, 0);
    chk({tag, "_frame_done"}, frame_done_o, 0);
    chk({tag, "_rd_bank"}, rd_bank_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_err_sync"}, err_sync_o, 0);
    chk({tag, "_peak_val"}, peak_val_o, 0);
    chk({tag, "_peak_addr"}, peak_addr_o, 0);
  endtask

  // Maximum over bins >= PEAK_SKIP, first occurrence of a tie wins.
  task automatic peak_of(output logic [DW-1:0] v, output logic [AW-1:0] a);
    v = fr[PEAK_SKIP];
    a = AW'(PEAK_SKIP);
    for (int i = PEAK_SKIP + 1; i < DEPTH; i++) begin
      if (fr[i] > v) begin
        v = fr[i];
        a = AW'(i);
      end
    end
  endtask

  task automatic do_start(input logic c);
    start_i = 1'b1;
    cont_i  = c;
    tick();
    start_i = 1'b0;
    exp_err = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_err_clr", err_sync_o, 0);
    chk("start_wr_done_clr", wr_done_o, 0);
    chk("start_wr_en", wr_en_o, 0);
  endtask

  task automatic sync_frame();
    din_valid_i = 1'b1;
    din_last_i  = 1'b0;
    din_i       = DW'($urandom);
    tick();
    chk("sync_nolast_wr_en", wr_en_o, 0);
    din_last_i = 1'b1;
    tick();
    chk("sync_last_wr_en", wr_en_o, 0);
    chk("sync_busy", busy_o, 1);
    idle_inputs();
  endtask

  // Drives n beats of bins b0.. into bank bnk and checks each resulting write.
  task automatic capt_beats(input logic bnk, input int b0, input int n, input int last_at,
                            input bit cont_m, input bit gaps, input bit use_fr,
                            input bit poke_start);
    int            bin;
    logic [DW-1:0] d;
    logic [AW:0]   ea;
    logic          fd_exp;
    logic [AW-1:0] bin_w;
    for (int k = 0; k < n; k++) begin
      bin = b0 + k;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        din_valid_i = 1'b0;
        din_last_i  = 1'($urandom_range(0, 1));
        din_i       = DW'($urandom);
        tick();
        chk("gap_wr_en", wr_en_o, 0);
        chk("gap_frame_done", frame_done_o, 0);
      end
      d = use_fr ? fr[bin] : DW'($urandom);
      fr[bin] = d;
      din_valid_i = 1'b1;
      din_last_i  = (bin == last_at);
      din_i       = d;
      cont_i      = 1'b0;
      start_i     = poke_start && (k == 2);
      tick();
      idle_inputs();
      bin_w  = bin[AW-1:0];
      ea     = {bnk, bin_w};
      fd_exp = (bin == DEPTH - 1);
      if ((bin == last_at) != fd_exp) exp_err = 1'b1;
      if (fd_exp) begin
        exp_rd = bnk;
`ifdef MAG_PEAK_TRACK_EN
        peak_of(exp_pv, exp_pa);
`endif
      end
      chk("beat_wr_en", wr_en_o, 1);
      chk("beat_wr_addr", wr_addr_o, ea);
      chk("beat_wr_data", wr_data_o, d);
      chk("beat_frame_done", frame_done_o, fd_exp);
      chk("beat_err_sync", err_sync_o, exp_err);
      chk("beat_rd_bank", rd_bank_o, exp_rd);
      chk("beat_wr_done", wr_done_o, !cont_m && fd_exp);
      chk("beat_busy", busy_o, !(!cont_m && fd_exp));
      chk("beat_peak_val", peak_val_o, exp_pv);
      chk("beat_peak_addr", peak_addr_o, exp_pa);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    exp_err = 1'b0;
    exp_rd  = 1'b0;
    exp_pv  = '0;
    exp_pa  = '0;
    rst_n   = 1'b0;
    cont_i  = 1'b0;
    din_i   = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Nothing is written before start + sync, even with last beats arriving.
    for (int k = 0; k < 4; k++) begin
      din_valid_i = 1'b1;
      din_last_i  = 1'b1;
      din_i       = DW'($urandom);
      tick();
      chk("idle_wr_en", wr_en_o, 0);
      chk("idle_busy", busy_o, 0);
    end
    idle_inputs();

    // Single-shot frame of 10..17, then a trailing sample that must be dropped.
    do_start(1'b0);
    sync_frame();
    for (int i = 0; i < DEPTH; i++) fr[i] = DW'(10 + i);
    capt_beats(1'b0, 0, DEPTH, DEPTH - 1, 1'b0, 1'b1, 1'b1, 1'b0);
    din_valid_i = 1'b1;
    din_i       = DW'(99);
    tick();
    idle_inputs();
    chk("done_extra_wr_en", wr_en_o, 0);
    chk("done_extra_fd", frame_done_o, 0);
    chk("done_wr_done_hold", wr_done_o, 1);
    chk("done_busy", busy_o, 0);

    // Continuous: three back-to-back frames, banks 0,1,0; a stray start is ignored.
    do_start(1'b1);
    sync_frame();
    capt_beats(1'b0, 0, DEPTH, DEPTH - 1, 1'b1, 1'b0, 1'b0, 1'b0);
    capt_beats(1'b1, 0, DEPTH, DEPTH - 1, 1'b1, 1'b0, 1'b0, 1'b1);
    capt_beats(1'b0, 0, DEPTH, DEPTH - 1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Early last at bin 4 in bank 1: frame discarded, restart at bin 0 same bank.
    capt_beats(1'b1, 0, 5, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    capt_beats(1'b1, 0, DEPTH, DEPTH - 1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Abort at bin 3 beats a simultaneous start and valid sample.
    capt_beats(1'b0, 0, 3, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    abort_i     = 1'b1;
    start_i     = 1'b1;
    din_valid_i = 1'b1;
    din_i       = DW'($urandom);
    tick();
    idle_inputs();
    chk("abort_wr_en", wr_en_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_err_hold", err_sync_o, exp_err);
    chk("abort_rd_bank_hold", rd_bank_o, exp_rd);
    tick();
    chk("abort_idle_busy", busy_o, 0);

    // Single-shot frame ending without din_last, with the known peak pattern.
    do_start(1'b0);
    sync_frame();
    fr[0] = 16'd900; fr[1] = 16'd5; fr[2] = 16'd70; fr[3] = 16'd70;
    fr[4] = 16'd3;   fr[5] = 16'd1; fr[6] = 16'd2;  fr[7] = 16'd0;
    capt_beats(1'b0, 0, DEPTH, -1, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef MAG_PEAK_TRACK_EN
    chk("pattern_peak_val", peak_val_o, 70);
    chk("pattern_peak_addr", peak_addr_o, 2);
`else
    chk("pattern_peak_val_off", peak_val_o, 0);
    chk("pattern_peak_addr_off", peak_addr_o, 0);
`endif
    abort_i = 1'b1;
    tick();
    idle_inputs();
    chk("abort_done_wr_done", wr_done_o, 0);
    chk("abort_done_err_hold", err_sync_o, 1);
    chk("abort_done_rd_bank", rd_bank_o, 0);

    // Asynchronous reset mid-frame with non-zero state everywhere.
    do_start(1'b1);
    sync_frame();
    capt_beats(1'b0, 0, DEPTH, DEPTH - 1, 1'b1, 1'b0, 1'b0, 1'b0);
    capt_beats(1'b1, 0, DEPTH, DEPTH - 1, 1'b1, 1'b0, 1'b0, 1'b0);
    capt_beats(1'b0, 0, 2, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    fr[0] = 16'hBEEF;
    capt_beats(1'b0, 0, 1, -1, 1'b1, 1'b0, 1'b1, 1'b0);
    din_valid_i = 1'b1;
    din_i       = DW'($urandom);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    exp_err = 1'b0;
    exp_rd  = 1'b0;
    exp_pv  = '0;
    exp_pa  = '0;
    tick();
    rst_n = 1'b1;
    idle_inputs();
    tick();

    // After reset: no write without start/sync; capture restarts at bank 0, bin 0.
    din_valid_i = 1'b1;
    din_last_i  = 1'b1;
    tick();
    idle_inputs();
    chk("postrst_wr_en", wr_en_o, 0);
    do_start(1'b0);
    sync_frame();
    capt_beats(1'b0, 0, 2, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
